// File: rtl/ps2_kb_fifo.sv
// ps2_kb_fifo: PS/2 device-to-host receiver feeding a first-word-fall-through scan-code FIFO.
// Optional build macro KB_PARITY_CHECK_EN: when defined, frames with even parity are rejected.
module ps2_kb_fifo #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    input  logic                     kb_rd,
    input  logic                     kb_ovf_clr,
    output logic [7:0]               kb_data,
    output logic                     kb_ready,
    output logic [$clog2(DEPTH):0]   kb_count,
    output logic                     kb_ovf,
    output logic                     kb_frame_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]    clkSync;
    logic [1:0]    dataSync;
    logic [3:0]    bitCnt;
    logic [9:0]    shiftReg;
    logic [TW-1:0] toCnt;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [CW-1:0] count;
    logic [10:0]   frame;
    logic          fall;
    logic          done;
    logic          timeout;
    logic          parityOk;
    logic          frameOk;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;

    // Frame decode and FIFO push/pop/drop decisions for the current cycle.
    always_comb begin
        fall    = !clkSync[1] && clkSync[2];
        frame   = {dataSync[1], shiftReg};
        done    = fall && bitCnt == 4'd10;
        timeout = !fall && bitCnt != 4'd0 && toCnt == TW'(TIMEOUT_CYC - 1);
`ifdef KB_PARITY_CHECK_EN
        parityOk = ^frame[9:1];
`else
        parityOk = 1'b1 | frame[9];
`endif
        frameOk = !frame[0] && frame[10] && parityOk;
        full    = count == CW'(DEPTH);
        push    = done && frameOk && (!full || kb_rd);
        pop     = kb_rd && count != '0;
        drop    = done && frameOk && full && !kb_rd;
    end

    // Bring the asynchronous PS/2 pins into the clk domain; clock gets an extra stage for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clkSync  <= 3'b111;
            dataSync <= 2'b11;
        end else begin
            clkSync  <= {clkSync[1:0], ps2_clk};
            dataSync <= {dataSync[0], ps2_data};
        end
    end

    // Shift in one bit per PS/2 falling edge; abandon a stalled partial frame after the timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitCnt   <= 4'd0;
            shiftReg <= '0;
            toCnt    <= '0;
        end else if (fall) begin
            shiftReg <= frame[10:1];
            bitCnt   <= done ? 4'd0 : bitCnt + 4'd1;
            toCnt    <= '0;
        end else if (timeout) begin
            bitCnt <= 4'd0;
            toCnt  <= '0;
        end else begin
            toCnt <= bitCnt != 4'd0 ? toCnt + TW'(1) : '0;
        end
    end

    // Error pulse and sticky overflow flag; a drop beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kb_frame_err <= 1'b0;
            kb_ovf       <= 1'b0;
        end else begin
            kb_frame_err <= (done && !frameOk) || timeout;
            kb_ovf       <= drop ? 1'b1 : kb_ovf_clr ? 1'b0 : kb_ovf;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            wrPtr <= push ? wrPtr + PW'(1) : wrPtr;
            rdPtr <= pop ? rdPtr + PW'(1) : rdPtr;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= frame[8:1];
    end

    assign kb_ready = count != '0;
    assign kb_data  = kb_ready ? mem[rdPtr] : 8'h00;
    assign kb_count = count;
endmodule
